ddc_accum: RTL and testbench
============================

DDC_ACCUM -- requirements
Module: ddc_accum

Interface
REQ-001 The parameter ACC_W SHALL default to 48 and set the signed width of each of the I and Q accumulators.
REQ-002 The parameter FIFO_DEPTH SHALL default to 4 and set the number of output FIFO entries, a power of two no smaller than 2.
REQ-003 The port list SHALL use one clock and one reset, with the reset asynchronous and active-low:
- s_axis_aclk  in  1  clock.
- s_axis_aresetn  in  1  asynchronous active-low reset.
REQ-004 The input ports SHALL be:
- din_valid  in  1  DDC sample strobe; there is no backpressure.
- din_data  in  64  {Q[63:32], I[31:0]}, each half a 29-bit signed value sign-extended to 32 bits.
- resync  in  1  synchronous restart of the current frame.
- dec_len  in  16  samples per frame minus 1, giving 1..65536 samples.
- out_shift  in  5  arithmetic right shift applied to each sum, 0..31.
- stat_clr  in  1  clears the sticky flags.
- m_axis_tready  in  1  downstream ready.
REQ-005 The output ports SHALL be:
- m_axis_tdata  out  64  {Q_sum[63:32], I_sum[31:0]}, each half signed.
- m_axis_tvalid  out  1  output word valid.
- drop_sticky  out  1  a completed frame was lost because the FIFO was full.
- sat_sticky  out  1  a result was saturated.

Function
REQ-006 Each din_valid cycle SHALL accept exactly one sample; cnt is the index of that sample within the current frame.
REQ-007 When cnt==0, the accumulators SHALL load the sign-extended sample, and dec_len SHALL be latched into len_q for the whole frame.
REQ-008 When cnt>0, the sample SHALL be added to the accumulators at full ACC_W width with no wrap.
REQ-009 When cnt==len_q on an accepted sample, the block SHALL form the frame sum including that sample, register it in the result stage, and reset cnt to 0.
REQ-010 The result stage SHALL compute, per channel, sum >>> out_shift (arithmetic shift), then saturate to signed 32 bits [-2^31, 2^31-1].
REQ-011 Saturation SHALL set sat_sticky.
REQ-012 The result SHALL be written to the FIFO on the cycle after the result stage is registered.
REQ-013 m_axis_tvalid SHALL rise 2 cycles after the edge that accepted the final sample, provided the FIFO was empty.
REQ-014 The output SHALL follow AXI-stream rules:
- tdata is held stable while tvalid=1 and tready=0.
- A word transfers only when tvalid=1 and tready=1.
- Output order is FIFO order.
REQ-015 When the FIFO is full, the pushed result SHALL be discarded, drop_sticky SHALL be set, and FIFO contents SHALL be unchanged.
REQ-016 When the FIFO is full and a pop occurs in the same cycle as the push, the push SHALL be accepted and no drop SHALL be flagged.
REQ-017 When resync=1, cnt and the accumulators SHALL clear at the next edge.
REQ-018 A sample arriving in the same cycle as resync SHALL be discarded.
REQ-019 resync SHALL leave the result stage and FIFO contents intact.
REQ-020 On the sticky flags, a set event SHALL take priority over stat_clr in the same cycle.
REQ-021 A change of dec_len mid-frame SHALL take effect only at the next frame start.
REQ-022 When dec_len=0, every accepted sample SHALL produce one output word.

Reset
REQ-023 While s_axis_aresetn=0, the following SHALL be held at zero or cleared:
- cnt, len_q, the accumulators and the result stage.
- m_axis_tdata=0 and m_axis_tvalid=0.
- drop_sticky=0 and sat_sticky=0.
- FIFO pointers, with the FIFO empty.
REQ-024 Reset asserted mid-frame or mid-transfer SHALL abandon all partial and queued data, with no output word emitted for them after release.
REQ-025 The first accepted sample after reset release SHALL start a new frame at cnt==0.

Configuration
REQ-026 Rounding SHALL be selected by the preprocessor macro DDC_ACCUM_ROUND_EN.
REQ-027 With DDC_ACCUM_ROUND_EN defined and out_shift>0, 2^(out_shift-1) SHALL be added to the sum before the shift, giving round-half-up before saturation.
REQ-028 Without DDC_ACCUM_ROUND_EN, the shift SHALL truncate toward negative infinity.
REQ-029 Latency SHALL be identical with and without DDC_ACCUM_ROUND_EN.

Structure
REQ-030 The shared package ddc_pkg SHALL hold DDC_DATA_W=32, DDC_SAMPLE_W=29, the default ACC_W, the default FIFO_DEPTH, and the saturation limit constants.
REQ-031 The output buffer SHALL be the sub-module ddc_accum_fifo, a synchronous first-word-fall-through FIFO with push, pop, full and empty signals.

Verification
REQ-032 Basic frame: dec_len=3, out_shift=0, four samples I=1000, Q=-1000, tready=1 -> one word I=4000, Q=-4000, with tvalid 2 cycles after the fourth sample.
REQ-033 Saturation: dec_len=15, out_shift=0, I=2^28-1 every sample -> I=2^31-1 and sat_sticky=1.
REQ-034 Backpressure: dec_len=0, tready=0, 6 samples -> 4 words queued, drop_sticky=1; the first 4 sample values are then output in order once tready=1.
REQ-035 Rounding with the macro: dec_len=1, out_shift=1, samples I=1 and I=2 -> I=2 with DDC_ACCUM_ROUND_EN, I=1 without.
REQ-036 resync: dec_len=3, 2 samples, then resync with a sample in the same cycle, then 4 samples of I=5 -> a single word I=20.
REQ-037 Reset mid-frame: s_axis_aresetn=0 after 2 of 4 samples, with 1 word queued -> tvalid=0 immediately and no stale word after release.

Source files
------------

// File: rtl/ddc_pkg.sv
// rtl/ddc_pkg.sv - shared widths, defaults, saturation limits and output word layout for ddc_accum
package ddc_pkg;

  localparam int DDC_DATA_W         = 32;
  localparam int DDC_SAMPLE_W       = 29;
  localparam int DDC_ACC_W_DEF      = 48;
  localparam int DDC_FIFO_DEPTH_DEF = 4;

  // Limits of a signed 32-bit result, kept wide so they compare against any accumulator width
  localparam logic signed [63:0] DDC_SAT_MAX = 64'sh0000_0000_7fff_ffff;
  localparam logic signed [63:0] DDC_SAT_MIN = 64'shffff_ffff_8000_0000;

  // Output word: Q in the upper half, I in the lower half
  typedef struct packed {
    logic signed [DDC_DATA_W-1:0] q;
    logic signed [DDC_DATA_W-1:0] i;
  } ddc_word_t;

endpackage

// File: rtl/ddc_accum_fifo.sv
// rtl/ddc_accum_fifo.sv - first-word-fall-through output FIFO that reports pushes lost to a full queue
module ddc_accum_fifo
  import ddc_pkg::*;
#(
  parameter int W     = 2 * DDC_DATA_W,
  parameter int DEPTH = DDC_FIFO_DEPTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  // Pointer arithmetic; a pop in the same cycle frees the slot a push into a full queue needs
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    drop_o   = push_i & full_o & ~do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the queue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the read port is masked while the queue is empty
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/ddc_accum.sv
// rtl/ddc_accum.sv - I/Q frame accumulator with shift, saturation and output FIFO; DDC_ACCUM_ROUND_EN enables round-half-up
module ddc_accum
  import ddc_pkg::*;
#(
  parameter int ACC_W      = DDC_ACC_W_DEF,
  parameter int FIFO_DEPTH = DDC_FIFO_DEPTH_DEF
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        din_valid,
  input  logic [63:0] din_data,
  input  logic        resync,
  input  logic [15:0] dec_len,
  input  logic [4:0]  out_shift,
  input  logic        stat_clr,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        drop_sticky,
  output logic        sat_sticky
);

  localparam int EXT_W = ACC_W + 1;

  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             len_q, len_d;
  logic signed [ACC_W-1:0] sum_i_q, sum_i_d;
  logic signed [ACC_W-1:0] sum_q_q, sum_q_d;
  logic                    fin_q, fin_d;
  ddc_word_t               res_q, res_d;
  logic                    res_vld_q, res_vld_d;
  logic                    sat_q, sat_d;
  logic                    drop_q, drop_d;

  logic signed [ACC_W-1:0] smp_i, smp_q;
  logic                    first;
  logic [15:0]             cur_len;
  logic [DDC_DATA_W:0]     shp_i, shp_q;
  logic                    sat_evt;
  logic                    fifo_full, fifo_empty, fifo_drop, fifo_pop;
  logic                    unused_pad;

  assign unused_pad = ^{din_data[63:32+DDC_SAMPLE_W], din_data[31:DDC_SAMPLE_W]};

  // Scale one channel sum and clamp it to 32 bits; the top bit of the result flags a clamp
  function automatic logic [DDC_DATA_W:0] shape(input logic signed [ACC_W-1:0] sum,
                                                input logic [4:0] sh);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    ext = {sum[ACC_W-1], sum};
`ifdef DDC_ACCUM_ROUND_EN
    if (sh != 5'd0) begin
      ext = ext + (EXT_W'(1) << (sh - 5'd1));
    end
`endif
    ext = ext >>> sh;
    hi  = EXT_W'(DDC_SAT_MAX);
    lo  = EXT_W'(DDC_SAT_MIN);
    if (ext > hi) begin
      return {1'b1, DDC_SAT_MAX[DDC_DATA_W-1:0]};
    end else if (ext < lo) begin
      return {1'b1, DDC_SAT_MIN[DDC_DATA_W-1:0]};
    end
    return {1'b0, ext[DDC_DATA_W-1:0]};
  endfunction

  // Sign-extend the 29-bit halves of the incoming sample to accumulator width
  always_comb begin
    smp_i = {{(ACC_W-DDC_SAMPLE_W){din_data[DDC_SAMPLE_W-1]}}, din_data[DDC_SAMPLE_W-1:0]};
    smp_q = {{(ACC_W-DDC_SAMPLE_W){din_data[32+DDC_SAMPLE_W-1]}}, din_data[32 +: DDC_SAMPLE_W]};
  end

  // Frame accumulation: the first sample loads and latches the frame length, the last flags completion
  always_comb begin
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_i_d = sum_i_q;
    sum_q_d = sum_q_q;
    fin_d   = 1'b0;
    first   = (cnt_q == 16'd0);
    cur_len = first ? dec_len : len_q;
    if (resync) begin
      cnt_d   = '0;
      sum_i_d = '0;
      sum_q_d = '0;
    end else if (din_valid) begin
      if (first) begin
        len_d   = dec_len;
        sum_i_d = smp_i;
        sum_q_d = smp_q;
      end else begin
        sum_i_d = sum_i_q + smp_i;
        sum_q_d = sum_q_q + smp_q;
      end
      if (cnt_q == cur_len) begin
        cnt_d = '0;
        fin_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Result stage: scale the completed sum one cycle after the frame closes, then hand it to the FIFO
  always_comb begin
    shp_i     = shape(sum_i_q, out_shift);
    shp_q     = shape(sum_q_q, out_shift);
    res_vld_d = fin_q;
    res_d     = res_q;
    if (fin_q) begin
      res_d.i = shp_i[DDC_DATA_W-1:0];
      res_d.q = shp_q[DDC_DATA_W-1:0];
    end
    sat_evt = fin_q & (shp_i[DDC_DATA_W] | shp_q[DDC_DATA_W]);
  end

  // Sticky flags: a new event in the same cycle beats a clear request
  always_comb begin
    sat_d  = sat_evt | (sat_q & ~stat_clr);
    drop_d = fifo_drop | (drop_q & ~stat_clr);
  end

  // State registers for the accumulator, result stage and flags
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cnt_q     <= '0;
      len_q     <= '0;
      sum_i_q   <= '0;
      sum_q_q   <= '0;
      fin_q     <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sum_i_q   <= sum_i_d;
      sum_q_q   <= sum_q_d;
      fin_q     <= fin_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
    end
  end

  assign fifo_pop = m_axis_tvalid & m_axis_tready;

  ddc_accum_fifo #(
    .W     (2 * DDC_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (s_axis_aclk),
    .rst_ni      (s_axis_aresetn),
    .push_i      (res_vld_q),
    .push_data_i (res_q),
    .pop_i       (fifo_pop),
    .rd_data_o   (m_axis_tdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign sat_sticky    = sat_q;
  assign drop_sticky   = drop_q;

endmodule

// File: tb/tb_ddc_accum.sv
// tb/tb_ddc_accum.sv - randomized and directed bench for ddc_accum against a frame-level reference model
module tb_ddc_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [63:0] din_data = '0;
  logic        resync = 1'b0;
  logic [15:0] dec_len = '0;
  logic [4:0]  out_shift = '0;
  logic        stat_clr = 1'b0;
  logic        tready = 1'b0;
  logic [63:0] tdata;
  logic        tvalid;
  logic        drop_sticky;
  logic        sat_sticky;

  int n_checks = 0;
  int n_errors = 0;

  longint      fr_i[$];
  longint      fr_q[$];
  int          fr_len = 0;
  logic [63:0] expq[$];
  bit          exp_sat = 1'b0;

  bit          prev_v = 1'b0;
  bit          prev_r = 1'b0;
  logic [63:0] prev_d = '0;

`ifdef DDC_ACCUM_ROUND_EN
  localparam logic [31:0] RND_EXP = 32'd2;
`else
  localparam logic [31:0] RND_EXP = 32'd1;
`endif

  ddc_accum dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .din_valid      (din_valid),
    .din_data       (din_data),
    .resync         (resync),
    .dec_len        (dec_len),
    .out_shift      (out_shift),
    .stat_clr       (stat_clr),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .drop_sticky    (drop_sticky),
    .sat_sticky     (sat_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame result from the arithmetic rules: scale, optional half-up rounding, clamp to 32 bits
  function automatic logic [31:0] ref_shape(input longint s, input int sh);
    longint r;
    r = s;
`ifdef DDC_ACCUM_ROUND_EN
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
    r = r >>> sh;
    if (r > 64'sd2147483647) begin
      exp_sat = 1'b1;
      return 32'h7fff_ffff;
    end
    if (r < -64'sd2147483648) begin
      exp_sat = 1'b1;
      return 32'h8000_0000;
    end
    return r[31:0];
  endfunction

  task automatic model_accept(input int i, input int q);
    longint si, sq;
    if (fr_i.size() == 0) fr_len = int'(dec_len);
    fr_i.push_back(longint'(i));
    fr_q.push_back(longint'(q));
    if (fr_i.size() == fr_len + 1) begin
      si = 0;
      sq = 0;
      foreach (fr_i[k]) begin
        si += fr_i[k];
        sq += fr_q[k];
      end
      expq.push_back({ref_shape(sq, int'(out_shift)), ref_shape(si, int'(out_shift))});
      fr_i.delete();
      fr_q.delete();
    end
  endtask

  task automatic drive(input bit v, input bit rs, input int i, input int q);
    din_valid = v;
    resync    = rs;
    din_data  = {32'(q), 32'(i)};
    if (rs) begin
      fr_i.delete();
      fr_q.delete();
    end else if (v) begin
      model_accept(i, q);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    resync    = 1'b0;
  endtask

  function automatic int rand29();
    int unsigned x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0:       return 268435455;
      1:       return -268435456;
      default: return int'({{3{x[28]}}, x[28:0]});
    endcase
  endfunction

  task automatic drain(input int budget);
    for (int c = 0; c < budget && expq.size() != 0; c++) @(posedge clk);
    #1;
    check("drain", 64'(expq.size()), 64'd0);
  endtask

  // Output monitor: every transfer must match the model queue and stalled words must hold
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          check("hold_valid", 64'(tvalid), 64'd1);
          check("hold_data", tdata, prev_d);
        end
        if (tvalid && tready) begin
          check("out_pending", 64'(expq.size() != 0), 64'd1);
          if (expq.size() != 0) check("out_word", tdata, expq.pop_front());
        end
        prev_v = tvalid;
        prev_r = tready;
        prev_d = tdata;
      end
    end
  end

  initial begin
    int sh_tab[5];
    sh_tab = '{0, 1, 3, 8, 20};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_drop", 64'(drop_sticky), 64'd0);
    check("rst_sat", 64'(sat_sticky), 64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tready = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with latency check
    dec_len = 16'd3;
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1000, -1000);
    @(negedge clk);
    check("lat_edge0", 64'(tvalid), 64'd0);
    @(negedge clk);
    check("lat_edge1", 64'(tvalid), 64'd0);
    @(negedge clk);
    check("lat_edge2", 64'(tvalid), 64'd1);
    check("basic_word", tdata, {32'hffff_f060, 32'h0000_0fa0});
    drain(10);

    // Saturation
    dec_len = 16'd15;
    for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, 268435455, 0);
    repeat (4) @(negedge clk);
    check("sat_set", 64'(sat_sticky), 64'd1);
    drain(10);

    // Backpressure with dec_len=0; clear request held while the drop occurs
    tready   = 1'b0;
    dec_len  = 16'd0;
    stat_clr = 1'b1;
    for (int k = 1; k <= 6; k++) drive(1'b1, 1'b0, k, -k);
    void'(expq.pop_back());
    void'(expq.pop_back());
    @(negedge clk);
    @(negedge clk);
    check("drop_vs_clr", 64'(drop_sticky), 64'd1);
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_set", 64'(drop_sticky), 64'd1);
    check("sat_clr", 64'(sat_sticky), 64'd0);
    check("bp_head", tdata, {32'hffff_ffff, 32'h0000_0001});
    check("bp_queued", 64'(expq.size()), 64'd4);
    @(posedge clk);
    #1;
    tready = 1'b1;
    drain(20);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("drop_clr", 64'(drop_sticky), 64'd0);

    // Rounding
    dec_len   = 16'd1;
    out_shift = 5'd1;
    drive(1'b1, 1'b0, 1, 0);
    drive(1'b1, 1'b0, 2, 0);
    repeat (3) @(negedge clk);
    check("round_word", 64'(tdata[31:0]), 64'(RND_EXP));
    drain(10);
    out_shift = 5'd0;

    // Resync discards partial frame and the coincident sample
    dec_len = 16'd3;
    drive(1'b1, 1'b0, 100, 1);
    drive(1'b1, 1'b0, 100, 1);
    drive(1'b1, 1'b1, 999, 9);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 5, 0);
    repeat (3) @(negedge clk);
    check("resync_word", tdata, 64'd20);
    drain(10);

    // Reset mid-frame with a word queued
    tready = 1'b0;
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 3, 3);
    repeat (3) @(negedge clk);
    check("rq_tvalid", 64'(tvalid), 64'd1);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 4, 4);
    drive(1'b1, 1'b0, 4, 4);
    rst_n = 1'b0;
    #1;
    check("rq_rst_tvalid", 64'(tvalid), 64'd0);
    check("rq_rst_tdata", tdata, 64'd0);
    expq.delete();
    fr_i.delete();
    fr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tready = 1'b1;
    repeat (8) @(negedge clk);
    check("no_stale", 64'(tvalid), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 7, -7);
    drain(10);

    // Randomized traffic
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    exp_sat  = 1'b0;
    for (int b = 0; b < 5; b++) begin
      out_shift = 5'(sh_tab[b]);
      for (int c = 0; c < 80; c++) begin
        dec_len = 16'($urandom_range(2, 7));
        tready  = (c % 2 == 0) || ($urandom_range(0, 1) == 1);
        drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), rand29(), rand29());
      end
      tready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
    end
    drain(50);
    check("rand_sat", 64'(sat_sticky), 64'(exp_sat));
    check("rand_drop", 64'(drop_sticky), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
